// File: rtl/alu_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// alu_sched_pkg
// Shared types and constants for the round-robin ALU scheduler.
//   sched_state_e : FSM state encoding (IDLE, EXEC, RESP)
//   OP_SUB        : subtract opcode of the shared ALU (used by requesters)
//   id_width()    : width of a requester index, never less than 1 bit
//   ID_W          : requester index width for the default requester count
// -----------------------------------------------------------------------------
package alu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } sched_state_e;

  localparam logic [2:0] OP_SUB = 3'b001;

  localparam int DEFAULT_NUM_REQ = 4;

  // A single requester still needs a 1-bit index so vectors stay legal.
  function automatic int id_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  localparam int ID_W = id_width(DEFAULT_NUM_REQ);

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler_if
// Requester-facing request/response bus of the ALU scheduler.
//   req_valid/req_ready   : per-requester request handshake
//   req_a/req_b           : operands, requester i at [i*WIDTH +: WIDTH]
//   req_op                : opcode, requester i at [i*OPW +: OPW]
//   resp_valid/resp_ready : per-requester response handshake (valid is one-hot)
//   resp_result           : shared result bus
// Modports: master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface alu_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int OPW     = 3
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*OPW-1:0]   req_op;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [WIDTH-1:0]         resp_result;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_result
  );

endinterface

// File: rtl/alu_rr_scheduler_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
// Combinational pointer-based round-robin pick: the first set request found
// searching upward from rr_ptr_i, wrapping modulo NUM_REQ.
//   req_i     : request vector
//   rr_ptr_i  : highest-priority requester index
//   gnt_oh_o  : one-hot grant (all zero when nothing requests)
//   gnt_idx_o : encoded grant index (0 when nothing requests)
//   any_gnt_o : at least one request present
// -----------------------------------------------------------------------------
module alu_rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDW-1:0]     gnt_idx_o,
  output logic               any_gnt_o
);

  logic [IDW:0]   sum_s;
  logic [IDW-1:0] idx_s;
  logic           hit_s;

  // Scan candidates in priority order; the first hit wins and later hits are ignored.
  always_comb begin
    sum_s     = '0;
    idx_s     = '0;
    hit_s     = 1'b0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s     = {1'b0, rr_ptr_i} + (IDW+1)'(k);
      // One conditional subtract is enough: pointer and offset are both < NUM_REQ.
      sum_s     = (sum_s >= (IDW+1)'(NUM_REQ)) ? (sum_s - (IDW+1)'(NUM_REQ)) : sum_s;
      idx_s     = sum_s[IDW-1:0];
      hit_s     = req_i[idx_s] & ~any_gnt_o;
      gnt_idx_o = hit_s ? idx_s : gnt_idx_o;
      any_gnt_o = any_gnt_o | req_i[idx_s];
    end
  end

  // Expand the encoded winner into a one-hot grant.
  always_comb begin
    gnt_oh_o            = '0;
    gnt_oh_o[gnt_idx_o] = any_gnt_o;
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
// Shares one combinational ALU between NUM_REQ requesters. A round-robin pick
// in IDLE captures the winner's operands into the ALU input registers, EXEC
// registers the ALU result, RESP presents it to the owner until accepted.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : requester request/response bus (slave side)
//   alu_a_o/b_o    : registered operands to the ALU
//   alu_opcode_o   : registered opcode to the ALU (passed through untouched)
//   alu_result_i   : combinational ALU result
//   busy_o         : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int OPW     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_rr_scheduler_if.slave    bus,
  output logic [WIDTH-1:0]     alu_a_o,
  output logic [WIDTH-1:0]     alu_b_o,
  output logic [OPW-1:0]       alu_opcode_o,
  input  logic [WIDTH-1:0]     alu_result_i,
  output logic                 busy_o
);

  localparam int IDW = id_width(NUM_REQ);

  sched_state_e        state_q;
  logic [IDW-1:0]      rr_ptr_q;
  logic [IDW-1:0]      rr_ptr_d;
  logic [IDW-1:0]      owner_id_q;
  logic [WIDTH-1:0]    alu_a_q;
  logic [WIDTH-1:0]    alu_b_q;
  logic [OPW-1:0]      alu_op_q;
  logic [WIDTH-1:0]    resp_result_q;
  logic [NUM_REQ-1:0]  resp_valid_q;
  logic                busy_q;

  logic [NUM_REQ-1:0]  gnt_oh_s;
  logic [IDW-1:0]      gnt_idx_s;
  logic                any_gnt_s;
  logic [NUM_REQ-1:0]  owner_oh_s;

  logic [WIDTH-1:0]    a_arr_s  [NUM_REQ];
  logic [WIDTH-1:0]    b_arr_s  [NUM_REQ];
  logic [OPW-1:0]      op_arr_s [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr_s[gi]  = bus.req_a[gi*WIDTH +: WIDTH];
    assign b_arr_s[gi]  = bus.req_b[gi*WIDTH +: WIDTH];
    assign op_arr_s[gi] = bus.req_op[gi*OPW +: OPW];
  end

  alu_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i     (bus.req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_oh_o  (gnt_oh_s),
    .gnt_idx_o (gnt_idx_s),
    .any_gnt_o (any_gnt_s)
  );

  // The winner just served drops to lowest priority.
  assign rr_ptr_d = (gnt_idx_s == IDW'(NUM_REQ-1)) ? '0 : (gnt_idx_s + IDW'(1));

  // One-hot view of the current owner for the response valid.
  always_comb begin
    owner_oh_s             = '0;
    owner_oh_s[owner_id_q] = 1'b1;
  end

  // Acceptance is only offered in IDLE; gating on rst_n keeps ready low while reset is held.
  assign bus.req_ready = (rst_n && (state_q == ST_IDLE)) ? gnt_oh_s : '0;

  // Scheduler FSM with registered ALU inputs, result, response valid and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      owner_id_q    <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      resp_result_q <= '0;
      resp_valid_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Any grant is by construction a valid&ready handshake.
          if (any_gnt_s) begin
            alu_a_q    <= a_arr_s[gnt_idx_s];
            alu_b_q    <= b_arr_s[gnt_idx_s];
            alu_op_q   <= op_arr_s[gnt_idx_s];
            owner_id_q <= gnt_idx_s;
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= 1'b1;
            state_q    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_result_q <= alu_result_i;
          resp_valid_q  <= owner_oh_s;
          state_q       <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owner's ready bit completes the response.
          if (bus.resp_ready[owner_id_q]) begin
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid_q <= '0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_a_o         = alu_a_q;
  assign alu_b_o         = alu_b_q;
  assign alu_opcode_o    = alu_op_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_scheduler
// Self-checking bench: a behavioural ALU drives alu_result, and a reference
// model of round-robin fairness (rank of each requester relative to the last
// one served) predicts every grant, operand capture and returned result.
// -----------------------------------------------------------------------------
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int OW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_rr_scheduler_if #(.NUM_REQ(N), .WIDTH(W), .OPW(OW)) bus ();

  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [OW-1:0] alu_op;
  logic [W-1:0]  alu_result;
  logic          busy;

  alu_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .OPW(OW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_opcode_o (alu_op),
    .alu_result_i (alu_result),
    .busy_o       (busy)
  );

  // Behavioural shared ALU: unsupported opcodes produce 0.
  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [OW-1:0] op);
    case (op)
      OP_SUB:  return a - b;
      3'b010:  return a + b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_op);

  // Requester-side stimulus state
  logic [W-1:0]  ra  [N];
  logic [W-1:0]  rb  [N];
  logic [OW-1:0] rop [N];
  logic [N-1:0]  rvalid;
  logic [N-1:0]  rresp_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int last_served;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W]   = ra[i];
      bus.req_b[i*W +: W]   = rb[i];
      bus.req_op[i*OW +: OW] = rop[i];
    end
    bus.req_valid  = rvalid;
    bus.resp_ready = rresp_ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fairness model: rank 0 is the requester right after the last one served.
  function automatic int model_pick(input logic [N-1:0] v);
    int best = -1;
    int best_rank = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int rank = (i - last_served - 1 + 2 * N) % N;
        if (rank < best_rank) begin
          best_rank = rank;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic new_req(input int i, input logic [OW-1:0] op);
    ra[i]  = $urandom;
    rb[i]  = $urandom;
    rop[i] = op;
  endtask

  // Full transaction from IDLE: grant, EXEC, RESP with optional hold and non-owner ready noise.
  task automatic transaction(input bit keep_valid, input int hold, input bit noise);
    int g;
    logic [W-1:0]  exp_res;
    logic [W-1:0]  exp_a;
    logic [W-1:0]  exp_b;
    logic [OW-1:0] exp_op;
    #1;
    g = model_pick(rvalid);
    check_eq("req_ready_grant", 32'(bus.req_ready), 32'(onehot(g)));
    check_eq("busy_idle", 32'(busy), 32'd0);
    if (g >= 0) begin
      exp_a   = ra[g];
      exp_b   = rb[g];
      exp_op  = rop[g];
      exp_res = alu_ref(exp_a, exp_b, exp_op);
      tick();
      last_served = g;
      if (keep_valid) new_req(g, rop[g]);
      else            rvalid[g] = 1'b0;
      apply();
      #1;
      check_eq("busy_exec", 32'(busy), 32'd1);
      check_eq("req_ready_exec", 32'(bus.req_ready), 32'd0);
      check_eq("resp_valid_exec", 32'(bus.resp_valid), 32'd0);
      check_eq("alu_a", alu_a, exp_a);
      check_eq("alu_b", alu_b, exp_b);
      check_eq("alu_op", 32'(alu_op), 32'(exp_op));
      tick();
      check_eq("resp_valid_owner", 32'(bus.resp_valid), 32'(onehot(g)));
      check_eq("resp_result", bus.resp_result, exp_res);
      check_eq("busy_resp", 32'(busy), 32'd1);
      for (int h = 0; h < hold; h++) begin
        rresp_ready = noise ? (N'($urandom) & ~onehot(g)) : '0;
        apply();
        tick();
        check_eq("resp_valid_hold", 32'(bus.resp_valid), 32'(onehot(g)));
        check_eq("resp_result_hold", bus.resp_result, exp_res);
        check_eq("req_ready_hold", 32'(bus.req_ready), 32'd0);
        check_eq("alu_a_hold", alu_a, exp_a);
      end
      rresp_ready = onehot(g) | (noise ? N'($urandom) : '0);
      apply();
      tick();
      rresp_ready = '0;
      apply();
      check_eq("resp_valid_done", 32'(bus.resp_valid), 32'd0);
      check_eq("busy_done", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) new_req(i, OP_SUB);
    rvalid      = '1;
    rresp_ready = '0;
    apply();
    last_served = N - 1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_resp_result", bus.resp_result, 32'd0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    check_eq("rst_alu_b", alu_b, 32'd0);
    check_eq("rst_alu_op", 32'(alu_op), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All requesters continuously asserting: expected order 0,1,2,3,0
    for (int k = 0; k < 5; k++) transaction(1'b1, 0, 1'b0);

    // Requester 1: 10 - 3
    rvalid = 4'b0010;
    ra[1] = 32'd10; rb[1] = 32'd3; rop[1] = OP_SUB;
    apply();
    transaction(1'b0, 0, 1'b0);

    // Requester 2: 0 - 1 wraps; response held for 5 cycles
    rvalid = 4'b0100;
    ra[2] = 32'd0; rb[2] = 32'd1; rop[2] = OP_SUB;
    apply();
    transaction(1'b0, 5, 1'b0);

    // Requester 0: unsupported opcode, non-owner ready bits asserted while waiting
    rvalid = 4'b0001;
    ra[0] = 32'd123; rb[0] = 32'd45; rop[0] = 3'b000;
    apply();
    transaction(1'b0, 3, 1'b1);

    // Reset while the op is in EXEC
    rvalid = 4'b1000;
    new_req(3, OP_SUB);
    apply();
    #1;
    check_eq("pre_rst_ready", 32'(bus.req_ready), 32'(4'b1000));
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_alu_a", alu_a, 32'd0);
    check_eq("mid_rst_alu_op", 32'(alu_op), 32'd0);
    check_eq("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    rvalid = '1;
    for (int i = 0; i < N; i++) new_req(i, 3'($urandom_range(0, 7)));
    apply();
    @(negedge clk);
    rst_n = 1'b1;
    last_served = N - 1;
    #1;
    check_eq("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    transaction(1'b0, 1, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        rvalid = '0;
        apply();
        #1;
        check_eq("idle_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
      end
      for (int i = 0; i < N; i++) begin
        if (!rvalid[i] && ($urandom_range(0, 1) == 1)) begin
          new_req(i, 3'($urandom_range(0, 7)));
          rvalid[i] = 1'b1;
        end
      end
      if (rvalid == '0) begin
        int j = $urandom_range(0, N - 1);
        new_req(j, OP_SUB);
        rvalid[j] = 1'b1;
      end
      apply();
      transaction(1'b0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
